// File: rtl/clock_pkg.sv
// Shared types and constants for the digital clock controller.
// Build option: CLOCK_ALARM_SET_EN adds the alarm hour/minute set states.
package clock_pkg;

  localparam int unsigned HOUR_MAX = 23;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned SEC_MAX  = 59;

`ifdef CLOCK_ALARM_SET_EN
  localparam int unsigned FieldW = 3;
`else
  localparam int unsigned FieldW = 2;
`endif

  localparam logic [2:0] FieldNone     = 3'd0;
  localparam logic [2:0] FieldHour     = 3'd1;
  localparam logic [2:0] FieldMin      = 3'd2;
  localparam logic [2:0] FieldSec      = 3'd3;
  localparam logic [2:0] FieldAlarmHr  = 3'd4;
  localparam logic [2:0] FieldAlarmMin = 3'd5;

  typedef enum logic [2:0] {
    StRun   = 3'd0,
    StSetH  = 3'd1,
    StSetM  = 3'd2,
    StSetS  = 3'd3,
    StSetAh = 3'd4,
    StSetAm = 3'd5
  } state_e;

  function automatic state_e next_mode(state_e st);
    state_e nxt;
    case (st)
      StRun:   nxt = StSetH;
      StSetH:  nxt = StSetM;
      StSetM:  nxt = StSetS;
`ifdef CLOCK_ALARM_SET_EN
      StSetS:  nxt = StSetAh;
      StSetAh: nxt = StSetAm;
`endif
      default: nxt = StRun;
    endcase
    return nxt;
  endfunction

  function automatic logic [2:0] field_of(state_e st);
    logic [2:0] f;
    case (st)
      StSetH:  f = FieldHour;
      StSetM:  f = FieldMin;
      StSetS:  f = FieldSec;
      StSetAh: f = FieldAlarmHr;
      StSetAm: f = FieldAlarmMin;
      default: f = FieldNone;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter with edit inc/dec and a rollover carry chain.
module wrap_counter #(
  parameter int unsigned MAX = 59,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  input  logic         carry_in,
  output logic [W-1:0] value,
  output logic         carry_out
);

  localparam logic [W-1:0] Max = W'(MAX);

  logic [W-1:0] value_q, value_d;

  // Carry only propagates from rollover, never from edits.
  assign carry_out = carry_in && (value_q == Max);
  assign value     = value_q;

  always_comb begin
    value_d = value_q;
    if (carry_in || (inc && !dec)) begin
      value_d = (value_q == Max) ? '0 : value_q + 1'b1;
    end else if (dec && !inc) begin
      value_d = (value_q == '0) ? Max : value_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Run/set mode sequencer and hh:mm:ss timekeeping for the digital clock.
// Build option: CLOCK_ALARM_SET_EN adds alarm set states and alarm outputs.
module clock_set_ctrl import clock_pkg::*; #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned TIMEOUT_S = 10,
  parameter int unsigned BLINK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic              btn_dec,
  output logic [4:0]        hour,
  output logic [5:0]        min,
  output logic [5:0]        sec,
  output logic [FieldW-1:0] field_sel,
  output logic              blink_on,
`ifdef CLOCK_ALARM_SET_EN
  output logic [4:0]        alarm_hour,
  output logic [5:0]        alarm_min,
  output logic              alarm_hit,
`endif
  output logic              tick_1hz
);

  localparam int unsigned PreW      = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int unsigned BlinkHalf = (CLK_FREQ / BLINK_DIV > 0) ? CLK_FREQ / BLINK_DIV : 1;
  localparam int unsigned BlinkW    = (BlinkHalf > 1) ? $clog2(BlinkHalf) : 1;
  localparam int unsigned ToW       = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S) : 1;

  localparam logic [PreW-1:0]   PreLast   = PreW'(CLK_FREQ - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BlinkHalf - 1);
  localparam logic [ToW-1:0]    ToLast    = ToW'((TIMEOUT_S > 0) ? TIMEOUT_S - 1 : 0);

  state_e            state_q, state_d;
  logic [PreW-1:0]   pre_q, pre_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_q, blink_d;
  logic [ToW-1:0]    to_cnt_q, to_cnt_d;

  logic tick, in_set, any_btn, edit_en, timeout_hit, exit_to_run, run_tick;
  logic sec_carry, min_carry, unused_hour_carry;

  assign tick        = (pre_q == PreLast);
  assign in_set      = (state_q != StRun);
  assign any_btn     = btn_mode | btn_inc | btn_dec;
  assign edit_en     = in_set & ~btn_mode;
  assign timeout_hit = (TIMEOUT_S != 0) && in_set && tick && !any_btn && (to_cnt_q == ToLast);
  assign exit_to_run = in_set && (state_d == StRun);
  assign run_tick    = !in_set && tick;

  always_comb begin
    state_d = state_q;
    if (btn_mode) begin
      state_d = next_mode(state_q);
    end else if (timeout_hit) begin
      state_d = StRun;
    end
  end

  // Leaving a set state restarts the second so the first increment is a full second away.
  always_comb begin
    pre_d = pre_q + 1'b1;
    if (exit_to_run || tick) begin
      pre_d = '0;
    end
  end

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (!in_set || any_btn || timeout_hit) begin
      to_cnt_d = '0;
    end else if (tick) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_d     = blink_q;
    if (!in_set || (state_d != state_q) || btn_inc || btn_dec) begin
      blink_cnt_d = '0;
      blink_d     = 1'b1;
    end else if (blink_cnt_q == BlinkLast) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      pre_q       <= '0;
      to_cnt_q    <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      to_cnt_q    <= to_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  wrap_counter #(.MAX(SEC_MAX)) u_sec (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (edit_en && (state_q == StSetS) && btn_inc),
    .dec      (edit_en && (state_q == StSetS) && btn_dec),
    .carry_in (run_tick),
    .value    (sec),
    .carry_out(sec_carry)
  );

  wrap_counter #(.MAX(MIN_MAX)) u_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (edit_en && (state_q == StSetM) && btn_inc),
    .dec      (edit_en && (state_q == StSetM) && btn_dec),
    .carry_in (sec_carry),
    .value    (min),
    .carry_out(min_carry)
  );

  wrap_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (edit_en && (state_q == StSetH) && btn_inc),
    .dec      (edit_en && (state_q == StSetH) && btn_dec),
    .carry_in (min_carry),
    .value    (hour),
    .carry_out(unused_hour_carry)
  );

`ifdef CLOCK_ALARM_SET_EN
  logic rolled_q, unused_ah_carry, unused_am_carry;

  wrap_counter #(.MAX(HOUR_MAX)) u_alarm_hour (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (edit_en && (state_q == StSetAh) && btn_inc),
    .dec      (edit_en && (state_q == StSetAh) && btn_dec),
    .carry_in (1'b0),
    .value    (alarm_hour),
    .carry_out(unused_ah_carry)
  );

  wrap_counter #(.MAX(MIN_MAX)) u_alarm_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (edit_en && (state_q == StSetAm) && btn_inc),
    .dec      (edit_en && (state_q == StSetAm) && btn_dec),
    .carry_in (1'b0),
    .value    (alarm_min),
    .carry_out(unused_am_carry)
  );

  // Marks the cycle right after seconds rolled to :00 while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rolled_q <= 1'b0;
    end else begin
      rolled_q <= sec_carry;
    end
  end

  assign alarm_hit = rolled_q && !in_set && (hour == alarm_hour) && (min == alarm_min);
`endif

  assign field_sel = FieldW'(field_of(state_q));
  assign blink_on  = blink_q;
  assign tick_1hz  = tick;

endmodule
